// File: rtl/alarm_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_bank_if
// Description : Time, edit, control and display signals for alarm_bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface alarm_bank_if #(
    parameter int N_ALARMS = 4,
    parameter int CH_W     = 2
);
    logic [4:0]          cur_hour;
    logic [5:0]          cur_min;
    logic [CH_W-1:0]     sel;
    logic                inc_min;
    logic                inc_hour;
    logic [N_ALARMS-1:0] en;
    logic                ack;
    logic                snooze;
    logic [N_ALARMS-1:0] ring;
    logic                any_ring;
    logic [6:0]          HEX4;
    logic [6:0]          HEX5;
    logic [6:0]          HEX6;
    logic [6:0]          HEX7;

    modport master (
        output cur_hour, cur_min, sel, inc_min, inc_hour, en, ack, snooze,
        input  ring, any_ring, HEX4, HEX5, HEX6, HEX7
    );

    modport slave (
        input  cur_hour, cur_min, sel, inc_min, inc_hour, en, ack, snooze,
        output ring, any_ring, HEX4, HEX5, HEX6, HEX7
    );
endinterface
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
// Module      : alarm_bank
// Description : N-channel alarm unit with ring/snooze timers and 7-seg view.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_bank #(
    parameter int N_ALARMS   = 4,
    parameter int CH_W       = 2,
    parameter int CLK_HZ     = 50_000_000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic         clk,
    input  logic         RST,
    alarm_bank_if.slave  bus
);

    localparam int c_TICK_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int c_SNZ_SEC = SNOOZE_MIN * 60;
    localparam int c_TMR_MAX = (RING_SEC > c_SNZ_SEC) ? RING_SEC : c_SNZ_SEC;
    localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX + 1) : 1;

    localparam logic [c_TMR_W-1:0]  c_RING_LD = c_TMR_W'(RING_SEC);
    localparam logic [c_TMR_W-1:0]  c_SNZ_LD  = c_TMR_W'(c_SNZ_SEC);
    localparam logic [c_TMR_W-1:0]  c_TMR_ONE = c_TMR_W'(1);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(CLK_HZ - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_RINGING = 2'd1;
    localparam logic [1:0] c_ST_SNOOZE  = 2'd2;

    localparam logic [6:0] c_SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;

    logic                r_inc_min_d;
    logic                r_inc_hour_d;
    logic                w_min_edge;
    logic                w_hour_edge;
    logic                w_sel_ok;

    logic [5:0]          r_min  [N_ALARMS];
    logic [4:0]          r_hour [N_ALARMS];

    logic [N_ALARMS-1:0] w_edit;
    logic [N_ALARMS-1:0] w_match;
    logic [N_ALARMS-1:0] r_match_d;
    logic [N_ALARMS-1:0] w_trig;

    logic [1:0]          r_state     [N_ALARMS];
    logic [1:0]          w_state_nxt [N_ALARMS];
    logic [c_TMR_W-1:0]  r_timer     [N_ALARMS];
    logic [c_TMR_W-1:0]  w_timer_nxt [N_ALARMS];

    logic [N_ALARMS-1:0] r_ring;
    logic [N_ALARMS-1:0] w_ring_nxt;
    logic                r_any_ring;

    logic [5:0]          w_disp_min;
    logic [4:0]          w_disp_hour;
    logic [6:0]          r_hex4, r_hex5, r_hex6, r_hex7;

    function automatic logic [6:0] seg7(input logic [5:0] d);
        case (d)
            6'd0:    seg7 = 7'b1000000;
            6'd1:    seg7 = 7'b1111001;
            6'd2:    seg7 = 7'b0100100;
            6'd3:    seg7 = 7'b0110000;
            6'd4:    seg7 = 7'b0011001;
            6'd5:    seg7 = 7'b0010010;
            6'd6:    seg7 = 7'b0000010;
            6'd7:    seg7 = 7'b1111000;
            6'd8:    seg7 = 7'b0000000;
            6'd9:    seg7 = 7'b0010000;
            default: seg7 = c_SEG_BLANK;
        endcase
    endfunction

    // 1 Hz time base: tick is high during the last count before wrap
    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk) begin
        if (RST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    assign w_min_edge  = bus.inc_min  & ~r_inc_min_d;
    assign w_hour_edge = bus.inc_hour & ~r_inc_hour_d;
    assign w_sel_ok    = (int'(bus.sel) < N_ALARMS);

    always_comb begin
        w_edit = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            w_edit[i] = w_sel_ok && (int'(bus.sel) == i) && (w_min_edge || w_hour_edge);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_inc_min_d  <= 1'b0;
            r_inc_hour_d <= 1'b0;
            for (int i = 0; i < N_ALARMS; i++) begin
                r_min[i]  <= '0;
                r_hour[i] <= '0;
            end
        end else begin
            r_inc_min_d  <= bus.inc_min;
            r_inc_hour_d <= bus.inc_hour;
            for (int i = 0; i < N_ALARMS; i++) begin
                if (w_edit[i] && w_min_edge) begin
                    r_min[i] <= (r_min[i] == 6'd59) ? 6'd0 : r_min[i] + 6'd1;
                end
                if (w_edit[i] && w_hour_edge) begin
                    r_hour[i] <= (r_hour[i] == 5'd23) ? 5'd0 : r_hour[i] + 5'd1;
                end
            end
        end
    end

    always_comb begin
        w_match = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            w_match[i] = bus.en[i] && (r_hour[i] == bus.cur_hour) && (r_min[i] == bus.cur_min);
        end
    end

    // Only the first cycle of a matching minute fires the channel
    assign w_trig = w_match & ~r_match_d;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_match_d  <= '0;
            r_ring     <= '0;
            r_any_ring <= 1'b0;
            for (int i = 0; i < N_ALARMS; i++) begin
                r_state[i] <= c_ST_IDLE;
                r_timer[i] <= '0;
            end
        end else begin
            r_match_d  <= w_match;
            r_ring     <= w_ring_nxt;
            r_any_ring <= |w_ring_nxt;
            for (int i = 0; i < N_ALARMS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_timer[i] <= w_timer_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_ALARMS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_timer_nxt[i] = r_timer[i];
            if (!bus.en[i] || w_edit[i]) begin
                w_state_nxt[i] = c_ST_IDLE;
            end else begin
                case (r_state[i])
                    c_ST_RINGING: begin
                        if (bus.ack) begin
                            w_state_nxt[i] = c_ST_IDLE;
                        end else if (bus.snooze) begin
                            w_state_nxt[i] = c_ST_SNOOZE;
                            w_timer_nxt[i] = c_SNZ_LD;
                        end else if (w_tick) begin
                            if (r_timer[i] <= c_TMR_ONE) begin
                                w_state_nxt[i] = c_ST_IDLE;
                            end else begin
                                w_timer_nxt[i] = r_timer[i] - 1'b1;
                            end
                        end
                    end
                    c_ST_SNOOZE: begin
                        if (bus.ack) begin
                            w_state_nxt[i] = c_ST_IDLE;
                        end else if (w_tick) begin
                            if (r_timer[i] <= c_TMR_ONE) begin
                                w_state_nxt[i] = c_ST_RINGING;
                                w_timer_nxt[i] = c_RING_LD;
                            end else begin
                                w_timer_nxt[i] = r_timer[i] - 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt[i] = c_ST_IDLE;
                        if (w_trig[i]) begin
                            w_state_nxt[i] = c_ST_RINGING;
                            w_timer_nxt[i] = c_RING_LD;
                        end
                    end
                endcase
            end
        end
    end

    // ring is registered from the next state so it tracks RINGING without extra lag
    always_comb begin
        w_ring_nxt = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            w_ring_nxt[i] = (w_state_nxt[i] == c_ST_RINGING);
        end
    end

    always_comb begin
        w_disp_min  = '0;
        w_disp_hour = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (int'(bus.sel) == i) begin
                w_disp_min  = r_min[i];
                w_disp_hour = r_hour[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_hex4 <= c_SEG_ZERO;
            r_hex5 <= c_SEG_ZERO;
            r_hex6 <= c_SEG_ZERO;
            r_hex7 <= c_SEG_ZERO;
        end else if (w_sel_ok) begin
            r_hex4 <= seg7(w_disp_min % 6'd10);
            r_hex5 <= seg7(w_disp_min / 6'd10);
            r_hex6 <= seg7({1'b0, w_disp_hour} % 6'd10);
            r_hex7 <= seg7({1'b0, w_disp_hour} / 6'd10);
        end else begin
            r_hex4 <= c_SEG_BLANK;
            r_hex5 <= c_SEG_BLANK;
            r_hex6 <= c_SEG_BLANK;
            r_hex7 <= c_SEG_BLANK;
        end
    end

    assign bus.ring     = r_ring;
    assign bus.any_ring = r_any_ring;
    assign bus.HEX4     = r_hex4;
    assign bus.HEX5     = r_hex5;
    assign bus.HEX6     = r_hex6;
    assign bus.HEX7     = r_hex7;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_bank
// Description : Directed plus random checks of alarm_bank against a time model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_bank;

    localparam int N          = 4;
    localparam int CLK_HZ     = 4;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_MIN = 1;
    localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

    logic clk = 1'b0;
    logic RST = 1'b1;

    alarm_bank_if #(.N_ALARMS(4), .CH_W(2)) bus  ();
    alarm_bank_if #(.N_ALARMS(3), .CH_W(2)) bus3 ();

    alarm_bank #(.N_ALARMS(4), .CH_W(2), .CLK_HZ(CLK_HZ), .RING_SEC(RING_SEC),
                 .SNOOZE_MIN(SNOOZE_MIN)) u_dut (.clk(clk), .RST(RST), .bus(bus));
    alarm_bank #(.N_ALARMS(3), .CH_W(2), .CLK_HZ(CLK_HZ), .RING_SEC(RING_SEC),
                 .SNOOZE_MIN(SNOOZE_MIN)) u_dut3 (.clk(clk), .RST(RST), .bus(bus3));

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model: alarm times as integers, channel mode plus seconds left
    int       m_min [N];
    int       m_hour [N];
    int       m_mode [N];
    int       m_left [N];
    bit       m_prev_match [N];
    bit       m_prev_im, m_prev_ih;
    int       m_cycle;
    logic [3:0] e_ring;
    logic [6:0] e_hex [4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit tick, em, eh, match, trig, edited;
        int s;
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                m_min[i] = 0; m_hour[i] = 0; m_mode[i] = M_IDLE; m_left[i] = 0;
                m_prev_match[i] = 0;
            end
            m_prev_im = 0; m_prev_ih = 0; m_cycle = 0; e_ring = '0;
            for (int d = 0; d < 4; d++) e_hex[d] = 7'b1000000;
            return;
        end
        tick = ((m_cycle % CLK_HZ) == CLK_HZ - 1);
        m_cycle++;
        em = bus.inc_min && !m_prev_im;
        eh = bus.inc_hour && !m_prev_ih;
        m_prev_im = bus.inc_min;
        m_prev_ih = bus.inc_hour;
        s = int'(bus.sel);
        if (s < N) begin
            e_hex[0] = seg_tab[m_min[s] % 10];
            e_hex[1] = seg_tab[m_min[s] / 10];
            e_hex[2] = seg_tab[m_hour[s] % 10];
            e_hex[3] = seg_tab[m_hour[s] / 10];
        end else begin
            for (int d = 0; d < 4; d++) e_hex[d] = 7'b1111111;
        end
        for (int i = 0; i < N; i++) begin
            match = bus.en[i] && (m_hour[i] == int'(bus.cur_hour)) && (m_min[i] == int'(bus.cur_min));
            trig = match && !m_prev_match[i];
            m_prev_match[i] = match;
            edited = (em || eh) && (s == i);
            if (!bus.en[i] || edited) m_mode[i] = M_IDLE;
            else if (m_mode[i] != M_IDLE && bus.ack) m_mode[i] = M_IDLE;
            else if (m_mode[i] == M_RING && bus.snooze) begin
                m_mode[i] = M_SNZ; m_left[i] = SNOOZE_MIN * 60;
            end else if (m_mode[i] == M_IDLE) begin
                if (trig) begin m_mode[i] = M_RING; m_left[i] = RING_SEC; end
            end else if (tick) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    if (m_mode[i] == M_RING) m_mode[i] = M_IDLE;
                    else begin m_mode[i] = M_RING; m_left[i] = RING_SEC; end
                end
            end
            if (edited && em) m_min[i] = (m_min[i] + 1) % 60;
            if (edited && eh) m_hour[i] = (m_hour[i] + 1) % 24;
            e_ring[i] = (m_mode[i] == M_RING);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("ring", 32'(bus.ring), 32'(e_ring));
        chk("any_ring", 32'(bus.any_ring), 32'(|e_ring));
        chk("HEX4", 32'(bus.HEX4), 32'(e_hex[0]));
        chk("HEX5", 32'(bus.HEX5), 32'(e_hex[1]));
        chk("HEX6", 32'(bus.HEX6), 32'(e_hex[2]));
        chk("HEX7", 32'(bus.HEX7), 32'(e_hex[3]));
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin bus.inc_min = 1'b1; cyc(); bus.inc_min = 1'b0; cyc(); end
    endtask

    task automatic pulse_hour(input int n);
        repeat (n) begin bus.inc_hour = 1'b1; cyc(); bus.inc_hour = 1'b0; cyc(); end
    endtask

    task automatic chk_hex(input string tag, input logic [27:0] exp);
        chk(tag, 32'({bus.HEX7, bus.HEX6, bus.HEX5, bus.HEX4}), 32'(exp));
    endtask

    initial begin
        int n;
        int ch;
        bus.cur_hour = '0; bus.cur_min = '0; bus.sel = '0; bus.inc_min = 0; bus.inc_hour = 0;
        bus.en = '0; bus.ack = 0; bus.snooze = 0;
        bus3.cur_hour = '0; bus3.cur_min = '0; bus3.sel = '0; bus3.inc_min = 0; bus3.inc_hour = 0;
        bus3.en = '0; bus3.ack = 0; bus3.snooze = 0;

        RST = 1'b1; cyc(); cyc();
        RST = 1'b0;
        chk("rst_ring", 32'(bus.ring), 32'd0);
        chk("rst_any", 32'(bus.any_ring), 32'd0);
        chk_hex("rst_hex", {4{7'b1000000}});

        // Edit channel 2 to 07:30, then wrap the minute
        bus.sel = 2'd2;
        pulse_hour(7); pulse_min(30); cyc();
        chk_hex("edit_0730", {7'b1000000, 7'b1111000, 7'b0110000, 7'b1000000});
        pulse_min(30); cyc();
        chk_hex("min_wrap", {7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000});
        pulse_min(30);

        // Match fires, auto-stops after three ticks, no retrigger
        bus.en = 4'b0100; bus.cur_hour = 5'd7; bus.cur_min = 6'd30; cyc();
        chk("fire", 32'(bus.ring), 32'h4);
        repeat (12) cyc();
        chk("auto_stop", 32'(bus.ring), 32'h0);
        repeat (20) cyc();
        chk("no_retrig", 32'(bus.ring), 32'h0);

        // Snooze, wake after 60 ticks, auto-stop, then ack during snooze
        bus.cur_min = 6'd31; cyc(); bus.cur_min = 6'd30; cyc();
        chk("refire", 32'(bus.ring), 32'h4);
        bus.snooze = 1'b1; cyc(); bus.snooze = 1'b0;
        chk("snooze_low", 32'(bus.ring), 32'h0);
        n = 0;
        while (bus.ring != 4'b0100 && n < 260) begin cyc(); n++; end
        chk("snooze_wake", 32'(bus.ring), 32'h4);
        n = 0;
        while (bus.ring != 4'b0000 && n < 16) begin cyc(); n++; end
        chk("wake_stop", 32'(bus.ring), 32'h0);
        bus.cur_min = 6'd31; cyc(); bus.cur_min = 6'd30; cyc();
        bus.snooze = 1'b1; cyc(); bus.snooze = 1'b0; cyc();
        bus.ack = 1'b1; cyc(); bus.ack = 1'b0;
        repeat (260) cyc();
        chk("snooze_ack", 32'(bus.ring), 32'h0);

        // Two channels at 08:15; ack beats snooze
        bus.en = 4'b0011;
        bus.sel = 2'd0; pulse_hour(8); pulse_min(15);
        bus.sel = 2'd1; pulse_hour(8); pulse_min(15);
        bus.cur_hour = 5'd8; bus.cur_min = 6'd15; cyc();
        chk("dual_fire", 32'(bus.ring), 32'h3);
        chk("dual_any", 32'(bus.any_ring), 32'h1);
        bus.ack = 1'b1; bus.snooze = 1'b1; cyc(); bus.ack = 1'b0; bus.snooze = 1'b0;
        chk("ack_wins", 32'(bus.ring), 32'h0);
        repeat (260) cyc();
        chk("ack_no_snz", 32'(bus.ring), 32'h0);

        // Enable drop and reset mid-ring
        bus.cur_min = 6'd16; cyc(); bus.cur_min = 6'd15; cyc();
        chk("refire2", 32'(bus.ring), 32'h3);
        bus.en = 4'b0001; cyc();
        chk("en_drop", 32'(bus.ring), 32'h1);
        RST = 1'b1; cyc(); RST = 1'b0;
        chk("mid_rst_ring", 32'(bus.ring), 32'h0);
        chk("mid_rst_any", 32'(bus.any_ring), 32'h0);
        chk_hex("mid_rst_hex", {4{7'b1000000}});

        // Three-channel instance: out-of-range select blanks and ignores edits
        bus3.sel = 2'd3; cyc();
        chk("blank_hex", 32'({bus3.HEX7, bus3.HEX6, bus3.HEX5, bus3.HEX4}), 32'({4{7'b1111111}}));
        bus3.inc_min = 1'b1; bus3.inc_hour = 1'b1; cyc();
        bus3.inc_min = 1'b0; bus3.inc_hour = 1'b0; cyc();
        for (int c = 0; c < 3; c++) begin
            bus3.sel = 2'(c); cyc();
            chk("n3_unchanged", 32'({bus3.HEX7, bus3.HEX6, bus3.HEX5, bus3.HEX4}),
                32'({4{7'b1000000}}));
        end
        chk("n3_ring", 32'(bus3.ring), 32'h0);

        // Random phase against the model
        bus.en = 4'b1111;
        repeat (3000) begin
            bus.sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus.inc_min = ~bus.inc_min;
            if ($urandom_range(0, 29) == 0) bus.inc_hour = ~bus.inc_hour;
            if ($urandom_range(0, 79) == 0) bus.en[$urandom_range(0, 3)] ^= 1'b1;
            bus.ack = ($urandom_range(0, 99) == 0);
            bus.snooze = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) begin
                ch = $urandom_range(0, N - 1);
                bus.cur_hour = 5'(m_hour[ch]);
                bus.cur_min = 6'(m_min[ch]);
            end else if ($urandom_range(0, 49) == 0) begin
                bus.cur_hour = 5'($urandom_range(0, 23));
                bus.cur_min = 6'($urandom_range(0, 59));
            end
            RST = ($urandom_range(0, 999) == 0);
            cyc();
        end
        RST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Multi-channel alarm unit replacing the single-alarm block in the clock design.
- Holds N_ALARMS independently settable alarm times and compares each against the running clock's current time.
- Drives per-channel ring outputs through a RINGING/SNOOZE state machine with auto-timeout and snooze.
- Shows the selected channel's alarm time on four active-low seven-segment digits.

Parameters:
- N_ALARMS, 4, number of alarm channels (1..8).
- CH_W, 2, width of the channel select (clog2 of N_ALARMS, min 1).
- CLK_HZ, 50_000_000, clk frequency; the internal 1 Hz tick period in cycles.
- RING_SEC, 60, seconds a channel rings before auto-stop.
- SNOOZE_MIN, 5, snooze length in minutes (SNOOZE_MIN*60 ticks).

Ports:
- clk  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- cur_hour  in  5  current hour, binary 0..23.
- cur_min  in  6  current minute, binary 0..59.
- sel  in  CH_W  channel being edited and displayed; values at or above N_ALARMS select nothing (display blank, edits ignored).
- inc_min  in  1  level input; each rising edge advances the selected channel's minute.
- inc_hour  in  1  level input; each rising edge advances the selected channel's hour.
- en  in  N_ALARMS  per-channel alarm enable.
- ack  in  1  level; stops every ringing or snoozing channel.
- snooze  in  1  level; moves every ringing channel to snooze.
- ring  out  N_ALARMS  per-channel ring indication.
- any_ring  out  1  OR of ring.
- HEX4  out  7  alarm minute ones digit (selected channel).
- HEX5  out  7  alarm minute tens digit.
- HEX6  out  7  alarm hour ones digit.
- HEX7  out  7  alarm hour tens digit.

Behaviour:
- Clocking and reset: single clock; RST is synchronous and active-high.
- Reset values:
  - All alarm times 00:00.
  - All channel states IDLE; ring = 0, any_ring = 0.
  - Tick counter, edge-detect registers and match history = 0.
  - HEX4..HEX7 = 7'b1000000 (digit "0").
- Tick: a counter runs 0..CLK_HZ-1; tick is a one-cycle pulse when the counter wraps.
- Edit path:
  - Rising edges of inc_min and inc_hour are detected using one registered copy of each.
  - A minute increment wraps 59 to 0 with no carry into the hour; an hour increment wraps 23 to 0.
  - Alarm times are stored in binary, minute 6 bits and hour 5 bits.
  - Editing a channel forces it to IDLE on the same edge.
  - If inc_min and inc_hour edges coincide, both are applied.
- Match: match[i] = en[i] && hour[i] == cur_hour && min[i] == cur_min. A trigger is the rising edge of match[i] (registered match_d[i]), so an alarm fires once per matching minute. Editing an enabled alarm onto the current time also fires it.
- Per-channel FSM with states IDLE, RINGING and SNOOZE:
  - IDLE to RINGING on trigger; the ring timer loads RING_SEC. ring[i] rises on the edge after match first holds (1-cycle latency).
  - RINGING decrements its timer on each tick. When the timer reaches 0, the channel goes to IDLE.
  - RINGING to SNOOZE on snooze; the timer loads SNOOZE_MIN*60.
  - RINGING to IDLE on ack.
  - SNOOZE decrements its timer on each tick. When the timer reaches 0, the channel goes to RINGING with the timer loaded to RING_SEC.
  - SNOOZE to IDLE on ack.
  - ack and snooze asserted together: ack wins.
  - A trigger that arrives while RINGING or SNOOZE is ignored.
  - en[i] low in any state forces IDLE on the next edge.
  - Priority, highest first: RST, en low, edit, ack, snooze, timer/trigger.
- Outputs:
  - ring[i] = (state == RINGING), registered.
  - any_ring is registered, aligned with ring.
  - HEX4..HEX7 are registered with 1-cycle latency from sel or time change. They show the selected channel's time as decimal digits, tens = value/10 and ones = value%10.
  - Segment encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
- Timer widths: sized to hold max(RING_SEC, SNOOZE_MIN*60).

Test Plan:
- Bench uses CLK_HZ=4, RING_SEC=3, SNOOZE_MIN=1, N_ALARMS=4.
- Reset then sel=2; pulse inc_hour 7 times and inc_min 30 times -> HEX7..HEX4 show 0,7,3,0. Pulse inc_min 30 more -> minute wraps to 00 with the hour still 07.
- Channel 2 at 07:30 with en=4'b0100; drive cur_hour=7, cur_min=30 -> ring=4'b0100 on the next edge. No ack -> ring clears after 3 ticks (12 cycles), and it does not retrigger while cur_min stays 30.
- Ringing channel with snooze pulsed -> ring low next cycle, high again after 60 ticks, then auto-stops after 3 more ticks. Ack during SNOOZE -> stays low.
- Two channels set to the same time -> ring=4'b0011. ack and snooze asserted together -> both go IDLE, neither snoozes.
- Ringing channel: en drops -> ring low next edge. Separately, RST asserted mid-ring -> all outputs return to reset values, including HEX="0000".
- sel=3 with N_ALARMS=3 -> HEX all 1111111, and inc pulses change no stored time.
